gpx_ram_wr_ctrl: RTL and testbench

Write-side controller for the 512x32 TDC-GPX result RAM. Frames stop-hit words from two TDC channels per laser shot, arbitrates them round-robin onto the single RAM write port, and manages the RAM as two 256-word ping-pong banks. Each completed frame is handed to the downstream reader with bank, length and overflow status. Sits between the GPX readout logic and the result RAM, in the same clock domain as the RAM write port.

---
 rtl/gpx_ram_wr_ctrl_pkg.sv | 29 ++
 rtl/gpx_ram_wr_ctrl_if.sv | 38 +++
 rtl/gpx_ram_wr_ctrl_rr_arb2.sv | 34 +++
 rtl/gpx_ram_wr_ctrl.sv | 160 ++++++++++++++++
 tb/tb_gpx_ram_wr_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpx_ram_wr_ctrl_pkg.sv
// Shared types and sizing for the GPX result-RAM write controller.
package gpx_ram_wr_ctrl_pkg;

    localparam int DATA_W  = 31;
    localparam int BANK_AW = 8;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_CLOSE = 2'd2
    } state_e;

    // One completed frame as handed to the reader.
    typedef struct packed {
        logic               bank;
        logic [BANK_AW:0]   len;
        logic               ovf;
    } frame_desc_t;

    // Saturating add of a small increment to a status counter.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                 input logic [1:0]       n);
        logic [CNT_W:0] s;
        s = {1'b0, c} + {{(CNT_W-1){1'b0}}, n};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/gpx_ram_wr_ctrl_if.sv
// Bus bundle between GPX readout, result RAM and frame reader.
interface gpx_ram_wr_ctrl_if;
    import gpx_ram_wr_ctrl_pkg::*;

    logic                shot_start;
    logic                shot_end;
    logic                ch0_valid;
    logic                ch1_valid;
    logic [DATA_W-1:0]   ch0_data;
    logic [DATA_W-1:0]   ch1_data;
    logic                ch0_ready;
    logic                ch1_ready;
    logic                wre_a;
    logic [BANK_AW:0]    wr_addr_a;
    logic [DATA_W:0]     wr_data_a;
    logic                frame_rdy;
    logic                frame_bank;
    logic [BANK_AW:0]    frame_len;
    logic                frame_ovf;
    logic                frame_ack;
    logic [CNT_W-1:0]    miss_cnt;
    logic [CNT_W-1:0]    drop_cnt;

    // Controller side.
    modport slave (
        input  shot_start, shot_end, ch0_valid, ch1_valid, ch0_data, ch1_data, frame_ack,
        output ch0_ready, ch1_ready, wre_a, wr_addr_a, wr_data_a,
        output frame_rdy, frame_bank, frame_len, frame_ovf, miss_cnt, drop_cnt
    );

    // Environment side.
    modport master (
        output shot_start, shot_end, ch0_valid, ch1_valid, ch0_data, ch1_data, frame_ack,
        input  ch0_ready, ch1_ready, wre_a, wr_addr_a, wr_data_a,
        input  frame_rdy, frame_bank, frame_len, frame_ovf, miss_cnt, drop_cnt
    );

endinterface

// File: rtl/gpx_ram_wr_ctrl_rr_arb2.sv
// Two-way round-robin grant; pointer favours the channel not served last.
module gpx_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_q, ptr_d;

    // One-hot grant: lone requester wins, ties go to the pointer.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
            else              gnt = req;
        end
    end

    // After a grant the pointer moves to the other channel.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt[0])      ptr_d = 1'b1;
        else if (gnt[1]) ptr_d = 1'b0;
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/gpx_ram_wr_ctrl.sv
// Frames two-channel GPX hits into ping-pong RAM banks and queues completed frames.
module gpx_ram_wr_ctrl
    import gpx_ram_wr_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    gpx_ram_wr_ctrl_if.slave  bus
);

    state_e              state_q, state_d;
    logic [1:0]          busy_q, busy_d;
    logic                next_bank_q, next_bank_d;
    logic                cur_bank_q, cur_bank_d;
    logic [BANK_AW:0]    off_q, off_d;
    logic                ovf_q, ovf_d;
    logic                wre_q, wre_d;
    logic [BANK_AW:0]    waddr_q, waddr_d;
    logic [DATA_W:0]     wdata_q, wdata_d;
    frame_desc_t [1:0]   fq_q, fq_d;
    logic [1:0]          fcnt_q, fcnt_d;
    logic [CNT_W-1:0]    miss_q, miss_d;
    logic [CNT_W-1:0]    drop_q, drop_d;

    logic                acq, full, arb_en, pop, push;
    logic [1:0]          req, gnt, rdy, acc;
    frame_desc_t         push_desc;

    assign acq    = (state_q == ST_ACQ);
    assign full   = off_q[BANK_AW];
    assign arb_en = acq && !full;
    assign req    = {bus.ch1_valid, bus.ch0_valid};

    gpx_rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req (req),
        .gnt (gnt)
    );

    // A full bank keeps both channels draining so upstream never stalls.
    assign rdy = !acq ? 2'b00 : (full ? 2'b11 : gnt);
    assign acc = rdy & req;

    assign pop       = bus.frame_ack && (fcnt_q != 2'd0);
    assign push      = (state_q == ST_CLOSE);
    assign push_desc = {cur_bank_q, off_q, ovf_q};

    assign bus.ch0_ready  = rdy[0];
    assign bus.ch1_ready  = rdy[1];
    assign bus.wre_a      = wre_q;
    assign bus.wr_addr_a  = waddr_q;
    assign bus.wr_data_a  = wdata_q;
    assign bus.frame_rdy  = (fcnt_q != 2'd0);
    assign bus.frame_bank = fq_q[0].bank;
    assign bus.frame_len  = fq_q[0].len;
    assign bus.frame_ovf  = fq_q[0].ovf;
    assign bus.miss_cnt   = miss_q;
    assign bus.drop_cnt   = drop_q;

    // Frame FSM, bank ownership, RAM write staging and status counters.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        next_bank_d = next_bank_q;
        cur_bank_d  = cur_bank_q;
        off_d       = off_q;
        ovf_d       = ovf_q;
        wre_d       = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        miss_d      = miss_q;
        drop_d      = drop_q;

        // Reader release; a queued bank is never the one being claimed below.
        if (pop) busy_d[fq_q[0].bank] = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.shot_start) begin
                    if (!busy_q[next_bank_q]) begin
                        busy_d[next_bank_q] = 1'b1;
                        cur_bank_d  = next_bank_q;
                        next_bank_d = !next_bank_q;
                        off_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = ST_ACQ;
                    end else begin
                        miss_d = sat_add(miss_q, 2'd1);
                    end
                end
            end
            ST_ACQ: begin
                if (!full) begin
                    if (|acc) begin
                        wre_d   = 1'b1;
                        waddr_d = {cur_bank_q, off_q[BANK_AW-1:0]};
                        wdata_d = acc[1] ? {1'b1, bus.ch1_data} : {1'b0, bus.ch0_data};
                        off_d   = off_q + 1'b1;
                    end
                end else if (|acc) begin
                    drop_d = sat_add(drop_q, {1'b0, acc[0]} + {1'b0, acc[1]});
                    ovf_d  = 1'b1;
                end
                if (bus.shot_end) state_d = ST_CLOSE;
            end
            ST_CLOSE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Two-entry completed-frame queue; slot 0 is the head shown to the reader.
    always_comb begin
        fq_d   = fq_q;
        fcnt_d = fcnt_q;
        if (pop) begin
            fq_d[0] = fq_q[1];
            fq_d[1] = '0;
            fcnt_d  = fcnt_q - 2'd1;
        end
        if (push) begin
            fq_d[fcnt_d[0]] = push_desc;
            fcnt_d          = fcnt_d + 2'd1;
        end
    end

    // State registers; reset drops the open frame and every queued frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= '0;
            next_bank_q <= 1'b0;
            cur_bank_q  <= 1'b0;
            off_q       <= '0;
            ovf_q       <= 1'b0;
            wre_q       <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            fq_q        <= '0;
            fcnt_q      <= '0;
            miss_q      <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            next_bank_q <= next_bank_d;
            cur_bank_q  <= cur_bank_d;
            off_q       <= off_d;
            ovf_q       <= ovf_d;
            wre_q       <= wre_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            fq_q        <= fq_d;
            fcnt_q      <= fcnt_d;
            miss_q      <= miss_d;
            drop_q      <= drop_d;
        end
    end

endmodule

// File: tb/tb_gpx_ram_wr_ctrl.sv
// Directed bench for the GPX result-RAM write controller.
module tb_gpx_ram_wr_ctrl;
    import gpx_ram_wr_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gpx_ram_wr_ctrl_if bus ();

    gpx_ram_wr_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [BANK_AW:0] wa_q[$];
    logic [DATA_W:0]  wd_q[$];
    logic mon_en = 1'b0;
    int   both_rdy = 0;

    // Record every RAM write and any double-ready during contention.
    always @(negedge clk) begin
        if (bus.wre_a) begin
            wa_q.push_back(bus.wr_addr_a);
            wd_q.push_back(bus.wr_data_a);
        end
        if (mon_en && bus.ch0_ready && bus.ch1_ready) both_rdy++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic ack();
        bus.frame_ack = 1'b1;
        cyc();
        bus.frame_ack = 1'b0;
    endtask

    task automatic close_frame();
        bus.shot_end = 1'b1;
        cyc();
        bus.shot_end = 1'b0;
        cyc();
    endtask

    task automatic open_frame();
        bus.shot_start = 1'b1;
        cyc();
        bus.shot_start = 1'b0;
    endtask

    task automatic clr_mon();
        wa_q.delete();
        wd_q.delete();
    endtask

    initial begin
        int bad;
        logic [DATA_W:0] exp_d;

        rst = 1'b1;
        bus.shot_start = 1'b0; bus.shot_end = 1'b0;
        bus.ch0_valid = 1'b0;  bus.ch1_valid = 1'b0;
        bus.ch0_data = '0;     bus.ch1_data = '0;
        bus.frame_ack = 1'b0;
        cyc(); cyc();
        rst = 1'b0;

        // Reset state
        chk("rst_wre",   bus.wre_a, 0);
        chk("rst_addr",  bus.wr_addr_a, 0);
        chk("rst_data",  bus.wr_data_a, 0);
        chk("rst_frdy",  bus.frame_rdy, 0);
        chk("rst_fbank", bus.frame_bank, 0);
        chk("rst_flen",  bus.frame_len, 0);
        chk("rst_fovf",  bus.frame_ovf, 0);
        chk("rst_miss",  bus.miss_cnt, 0);
        chk("rst_drop",  bus.drop_cnt, 0);
        chk("rst_rdy",   {bus.ch1_ready, bus.ch0_ready}, 0);
        cyc();

        // Single frame, alternating channels, bank 0
        open_frame();
        clr_mon();
        for (int i = 0; i < 5; i++) begin
            bus.ch0_valid = (i % 2 == 0);
            bus.ch1_valid = (i % 2 == 1);
            bus.ch0_data  = 31'h100 + 31'(i);
            bus.ch1_data  = 31'h200 + 31'(i);
            #1;
            if (i == 0) chk("t1_ready", {bus.ch1_ready, bus.ch0_ready}, 2'b01);
            cyc();
            if (i == 0) begin
                chk("t1_lat_wre",  bus.wre_a, 1);
                chk("t1_lat_addr", bus.wr_addr_a, 9'h000);
            end
        end
        bus.ch0_valid = 1'b0; bus.ch1_valid = 1'b0;
        bus.shot_end = 1'b1;
        cyc();
        bus.shot_end = 1'b0;
        chk("t1_frdy_early", bus.frame_rdy, 0);
        cyc();
        chk("t1_frdy",  bus.frame_rdy, 1);
        chk("t1_fbank", bus.frame_bank, 0);
        chk("t1_flen",  bus.frame_len, 5);
        chk("t1_fovf",  bus.frame_ovf, 0);
        chk("t1_nwr",   wa_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            exp_d = (i % 2 == 0) ? {1'b0, 31'h100 + 31'(i)} : {1'b1, 31'h200 + 31'(i)};
            chk("t1_addr", wa_q[i], i);
            chk("t1_data", wd_q[i], exp_d);
        end
        ack();
        chk("t1_ack", bus.frame_rdy, 0);

        // Contention on bank 1; a lone ch1 word first parks the pointer on ch0
        open_frame();
        clr_mon();
        bus.ch1_valid = 1'b1; bus.ch1_data = 31'h2ff;
        cyc();
        mon_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.ch0_valid = 1'b1; bus.ch1_valid = 1'b1;
            bus.ch0_data = 31'h300 + 31'(i);
            bus.ch1_data = 31'h400 + 31'(i);
            #1;
            chk("t2_gnt", {bus.ch1_ready, bus.ch0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
            cyc();
        end
        bus.ch0_valid = 1'b0; bus.ch1_valid = 1'b0;
        mon_en = 1'b0;
        close_frame();
        chk("t2_both_rdy", both_rdy, 0);
        chk("t2_fbank", bus.frame_bank, 1);
        chk("t2_flen",  bus.frame_len, 7);
        chk("t2_nwr",   wa_q.size(), 7);
        chk("t2_addr0", wa_q[0], 9'h100);
        chk("t2_data0", wd_q[0], {1'b1, 31'h2ff});
        for (int k = 1; k < 7; k++) begin
            exp_d = ((k - 1) % 2 == 0) ? {1'b0, 31'h300 + 31'(k - 1)} : {1'b1, 31'h400 + 31'(k - 1)};
            chk("t2_addr", wa_q[k], 9'h100 + 9'(k));
            chk("t2_data", wd_q[k], exp_d);
        end
        ack();

        // Ping-pong and miss: frames on banks 0 and 1, third start refused
        open_frame(); close_frame();
        open_frame(); close_frame();
        open_frame();
        chk("t3_miss",  bus.miss_cnt, 1);
        chk("t3_frdy",  bus.frame_rdy, 1);
        chk("t3_head0", bus.frame_bank, 0);
        ack();
        chk("t3_head1", bus.frame_bank, 1);
        chk("t3_len1",  bus.frame_len, 0);
        clr_mon();
        open_frame();
        bus.ch0_valid = 1'b1; bus.ch0_data = 31'h55;
        cyc();
        bus.ch0_valid = 1'b0;
        chk("t3_reuse_wre",  bus.wre_a, 1);
        chk("t3_reuse_addr", bus.wr_addr_a, 9'h000);
        chk("t3_reuse_data", bus.wr_data_a, {1'b0, 31'h55});
        close_frame();
        chk("t3_head_keep", bus.frame_bank, 1);
        ack();
        chk("t3_next_bank", bus.frame_bank, 0);
        chk("t3_next_len",  bus.frame_len, 1);
        ack();
        chk("t3_empty", bus.frame_rdy, 0);

        // Boundaries: shot_end in IDLE, start+end together, empty frame
        bus.shot_end = 1'b1;
        cyc();
        bus.shot_end = 1'b0;
        bus.ch0_valid = 1'b1;
        #1;
        chk("t4_idle_rdy", bus.ch0_ready, 0);
        cyc();
        chk("t4_idle_frdy", bus.frame_rdy, 0);
        bus.ch0_valid = 1'b0;
        bus.shot_start = 1'b1; bus.shot_end = 1'b1;
        cyc();
        bus.shot_start = 1'b0; bus.shot_end = 1'b0;
        bus.ch0_valid = 1'b1; bus.ch0_data = 31'h77;
        #1;
        chk("t4_se_rdy", bus.ch0_ready, 1);
        bus.shot_end = 1'b1;
        cyc();
        bus.ch0_valid = 1'b0; bus.shot_end = 1'b0;
        chk("t4_last_wre",  bus.wre_a, 1);
        chk("t4_last_addr", bus.wr_addr_a, 9'h100);
        chk("t4_last_data", bus.wr_data_a, {1'b0, 31'h77});
        cyc();
        chk("t4_se_frdy", bus.frame_rdy, 1);
        chk("t4_se_bank", bus.frame_bank, 1);
        chk("t4_se_len",  bus.frame_len, 1);
        ack();
        open_frame(); close_frame();
        chk("t4_e_frdy", bus.frame_rdy, 1);
        chk("t4_e_bank", bus.frame_bank, 0);
        chk("t4_e_len",  bus.frame_len, 0);
        chk("t4_e_ovf",  bus.frame_ovf, 0);
        ack();

        // Overflow: 260 words into bank 1, last 4 dropped
        open_frame();
        clr_mon();
        for (int i = 0; i < 260; i++) begin
            bus.ch0_valid = 1'b1; bus.ch0_data = 31'(i);
            if (i == 258) begin
                #1;
                chk("t5_full_rdy", {bus.ch1_ready, bus.ch0_ready}, 2'b11);
            end
            cyc();
        end
        bus.ch0_valid = 1'b0;
        close_frame();
        chk("t5_nwr", wa_q.size(), 256);
        bad = 0;
        for (int k = 0; k < wa_q.size(); k++)
            if (wa_q[k] !== 9'h100 + 9'(k) || wd_q[k] !== {1'b0, 31'(k)}) bad++;
        chk("t5_words", bad, 0);
        chk("t5_fbank", bus.frame_bank, 1);
        chk("t5_flen",  bus.frame_len, 256);
        chk("t5_fovf",  bus.frame_ovf, 1);
        chk("t5_drop",  bus.drop_cnt, 4);

        // Reset mid-frame with a frame still queued
        open_frame();
        for (int i = 0; i < 3; i++) begin
            bus.ch0_valid = 1'b1; bus.ch0_data = 31'h900 + 31'(i);
            cyc();
        end
        rst = 1'b1;
        cyc();
        clr_mon();
        chk("t6_wre",   bus.wre_a, 0);
        chk("t6_addr",  bus.wr_addr_a, 0);
        chk("t6_data",  bus.wr_data_a, 0);
        chk("t6_frdy",  bus.frame_rdy, 0);
        chk("t6_flen",  bus.frame_len, 0);
        chk("t6_fovf",  bus.frame_ovf, 0);
        chk("t6_miss",  bus.miss_cnt, 0);
        chk("t6_drop",  bus.drop_cnt, 0);
        chk("t6_rdy",   {bus.ch1_ready, bus.ch0_ready}, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        chk("t6_no_wr",  wa_q.size(), 0);
        chk("t6_rdy_idle", {bus.ch1_ready, bus.ch0_ready}, 0);
        bus.ch0_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
